// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and digit width.
package adder_pkg;

    // Controller states of the digit-serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits processed per cycle by the carry-lookahead slice.
    localparam int DIGIT_W = 2;

endpackage

// File: rtl/sum2b.sv
// 2-bit carry-lookahead adder slice: sum, carry-out and group propagate/generate.
module sum2b (
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       cin,
    output logic [1:0] s,
    output logic       cout,
    output logic       p,
    output logic       g
);

    logic [1:0] bit_p;
    logic [1:0] bit_g;
    logic       c1;

    // Bit propagate/generate, lookahead carries and sum bits.
    always_comb begin
        bit_p = a ^ b;
        bit_g = a & b;
        c1    = bit_g[0] | (bit_p[0] & cin);
        s     = {bit_p[1] ^ c1, bit_p[0] ^ cin};
        cout  = bit_g[1] | (bit_p[1] & bit_g[0]) | (bit_p[1] & bit_p[0] & cin);
        p     = bit_p[1] & bit_p[0];
        g     = bit_g[1] | (bit_p[1] & bit_g[0]);
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial W-bit adder: one 2-bit digit per cycle through a sum2b slice, LSB digit first,
// with valid/ready handshakes on operands and result.
module digit_serial_adder #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         ovf
);

    import adder_pkg::*;

    localparam int DIGITS = W / DIGIT_W;
    localparam int CNT_W  = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [W-1:0]       a_sh;
    logic [W-1:0]       b_sh;
    logic               carry;
    logic               sign_a;
    logic               sign_b;
    logic [CNT_W-1:0]   cnt;
    logic               last_digit;

    logic [DIGIT_W-1:0] slice_s;
    logic               slice_cout;
    logic               slice_p_unused;
    logic               slice_g_unused;

    assign last_digit = (cnt == LAST_DIGIT);

    sum2b u_sum2b (
        .a    (a_sh[DIGIT_W-1:0]),
        .b    (b_sh[DIGIT_W-1:0]),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout),
        .p    (slice_p_unused),
        .g    (slice_g_unused)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last_digit) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, per-digit shifting, carry chaining and result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum    <= '0;
            carry  <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            cnt    <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        carry  <= c_in;
                        sign_a <= a[W-1];
                        sign_b <= b[W-1];
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    // New digit enters at the top so the LSB digit ends up at bit 0.
                    sum   <= {slice_s, sum[W-1:DIGIT_W]};
                    a_sh  <= a_sh >> DIGIT_W;
                    b_sh  <= b_sh >> DIGIT_W;
                    carry <= slice_cout;
                    if (last_digit) begin
                        // slice_s[1] is the final sum MSB being written this edge.
                        cnt   <= '0;
                        c_out <= slice_cout;
                        ovf   <= (sign_a == sign_b) && (slice_s[1] != sign_a);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
